// File: rtl/psr_stack_if.sv
// Bus between the flag/sequencing logic and psr_stack: flag writes, push/pop
// requests and the PSR/stack status returned to the controller.
interface psr_stack_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] flags;
   logic [WIDTH-1:0] flag_we;
   logic             push;
   logic             pop;
   logic             err_clr;
   logic [WIDTH-1:0] readFlags;
   logic [CW-1:0]    depth_cnt;
   logic             full;
   logic             empty;
   logic             overflow;
   logic             underflow;

   modport master (
      output flags, flag_we, push, pop, err_clr,
      input  readFlags, depth_cnt, full, empty, overflow, underflow
   );

   modport slave (
      input  flags, flag_we, push, pop, err_clr,
      output readFlags, depth_cnt, full, empty, overflow, underflow
   );
endinterface

// File: rtl/psr_stack.sv
// Processor status register with per-bit write mask and a LIFO save stack.
// Optional macro PSR_BYPASS_EN: forward masked flag writes to readFlags in the same cycle.
module psr_stack #(
   parameter int unsigned      WIDTH     = 16,
   parameter int unsigned      DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input logic        clk,
   input logic        reset,
   psr_stack_if.slave bus
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] psr_q, psr_d;
   logic [WIDTH-1:0] stack_q [DEPTH];
   logic [WIDTH-1:0] stack_d [DEPTH];
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;
   logic [WIDTH-1:0] merged;
   logic [WIDTH-1:0] top;
   logic             full_w, empty_w;

   assign full_w  = (cnt_q == CW'(DEPTH));
   assign empty_w = (cnt_q == '0);
   assign merged  = (psr_q & ~bus.flag_we) | (bus.flags & bus.flag_we);

   always_comb begin
      top = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (cnt_q == CW'(i + 1)) top = stack_q[i];
      end
   end

   // Error clear is applied first so a fresh error in the same cycle wins.
   always_comb begin
      psr_d   = merged;
      stack_d = stack_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q & ~bus.err_clr;
      udf_d   = udf_q & ~bus.err_clr;
      if (bus.push && !bus.pop) begin
         if (full_w) begin
            ovf_d = 1'b1;
         end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
               if (cnt_q == CW'(i)) stack_d[i] = psr_q;
            end
            cnt_d = cnt_q + CW'(1);
         end
      end else if (bus.pop && !bus.push) begin
         if (empty_w) begin
            udf_d = 1'b1;
         end else begin
            psr_d = top;
            cnt_d = cnt_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         psr_q <= RESET_VAL;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) stack_q[i] <= '0;
      end else begin
         psr_q   <= psr_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
         stack_q <= stack_d;
      end
   end

`ifdef PSR_BYPASS_EN
   assign bus.readFlags = ((|bus.flag_we) && !bus.pop) ? merged : psr_q;
`else
   assign bus.readFlags = psr_q;
`endif
   assign bus.depth_cnt = cnt_q;
   assign bus.full      = full_w;
   assign bus.empty     = empty_w;
   assign bus.overflow  = ovf_q;
   assign bus.underflow = udf_q;
endmodule
